// File: rtl/decoder_pkg.sv
// Shared constants, types and helpers for the K=3, rate-1/2 Viterbi frame decoder.
// Code polynomials are g0=7, g1=5 over the shift register {u, s[1], s[0]}.
package decoder_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ACS   = 3'd2,
    TRACE = 3'd3,
    DONE  = 3'd4
  } fsm_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int x = value - 1; x > 0; x = x >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Expected coded pair {c0, c1} leaving state s with input bit u.
  function automatic logic [1:0] code_pair(input state_t s, input logic u);
    logic [2:0] sr;
    sr = {u, s};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Combinational add-compare-select for one trellis step of the 4-state code.
// Predecessors of next state {a,b} are {b,0} and {b,1}; ties keep {b,0}.
module viterbi_acs
  import decoder_pkg::*;
#(
  parameter int MET_W = 6
) (
  input  logic [3:0][MET_W-1:0] pm_i,
  input  logic [1:0]            rx_i,
  output logic [3:0][MET_W-1:0] pm_o,
  output logic [3:0]            dec_o
);

  logic [3:0][MET_W-1:0] m0_s;
  logic [3:0][MET_W-1:0] m1_s;

  function automatic logic [MET_W-1:0] sat_add(input logic [MET_W-1:0] a, input logic [1:0] b);
    logic [MET_W:0] sum;
    sum = {1'b0, a} + {{(MET_W-1){1'b0}}, b};
    if (sum[MET_W]) begin
      return {MET_W{1'b1}};
    end else begin
      return sum[MET_W-1:0];
    end
  endfunction

  // Candidate metrics from both predecessors, then select the smaller one.
  always_comb begin
    m0_s  = '0;
    m1_s  = '0;
    pm_o  = '0;
    dec_o = 4'b0000;
    for (int ns = 0; ns < NUM_STATES; ns++) begin
      m0_s[ns] = sat_add(pm_i[{ns[0], 1'b0}], hamming2(code_pair({ns[0], 1'b0}, ns[1]), rx_i));
      m1_s[ns] = sat_add(pm_i[{ns[0], 1'b1}], hamming2(code_pair({ns[0], 1'b1}, ns[1]), rx_i));
      if (m1_s[ns] < m0_s[ns]) begin
        pm_o[ns]  = m1_s[ns];
        dec_o[ns] = 1'b1;
      end else begin
        pm_o[ns]  = m0_s[ns];
        dec_o[ns] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/viterbi_frame_decoder.sv
// Hard-decision Viterbi decoder for a terminated rate-1/2 K=3 frame received over
// NUM_BEATS beats; reports the decoded message, winning path metric and truncation.
module viterbi_frame_decoder
  import decoder_pkg::*;
#(
  parameter int  MSG_LEN   = 16,
  parameter int  BEAT_W    = 12,
  localparam int NUM_BEATS = 2 * (MSG_LEN + 2) / BEAT_W,
  localparam int MET_W     = clog2(2 * (MSG_LEN + 2) + 1)
) (
  input  logic               clk_p_i,
  input  logic               reset_p_i,
  input  logic               start_i,
  input  logic [BEAT_W-1:0]  data_i,
  output logic               busy_o,
  output logic [MSG_LEN-1:0] data_o,
  output logic [MET_W-1:0]   metric_o,
  output logic               done_o,
  output logic               frame_err_o
);

  localparam int STEPS = MSG_LEN + 2;
  localparam int CW_W  = 2 * STEPS;
  localparam int SW    = clog2(STEPS);
  localparam int CNT_W = clog2(NUM_BEATS + 1);
  localparam logic [3:0][MET_W-1:0] PM_INIT = {{(3 * MET_W){1'b1}}, {MET_W{1'b0}}};

  if (((BEAT_W % 2) != 0) || (((2 * (MSG_LEN + 2)) % BEAT_W) != 0)) begin : g_param_check
    $error("viterbi_frame_decoder: BEAT_W must be even and divide 2*(MSG_LEN+2)");
  end

  fsm_t                    state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CW_W-1:0]         cw_q, cw_d;
  logic [3:0][MET_W-1:0]   pm_q, pm_d;
  logic [STEPS-1:0][3:0]   surv_q, surv_d;
  logic [SW-1:0]           step_q, step_d;
  state_t                  cur_q, cur_d;
  logic [MSG_LEN-1:0]      msg_q, msg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;
  logic [MSG_LEN-1:0]      data_q, data_d;
  logic [MET_W-1:0]        metric_q, metric_d;

  logic [CW_W+BEAT_W-1:0]  cw_shift_s;
  logic [3:0][MET_W-1:0]   pm_acs_s;
  logic [3:0]              dec_s;

  assign cw_shift_s = {cw_q, data_i};

  // The received pair for the current step always sits in the top two bits of cw_q.
  viterbi_acs #(
    .MET_W (MET_W)
  ) u_acs (
    .pm_i  (pm_q),
    .rx_i  (cw_q[CW_W-1 -: 2]),
    .pm_o  (pm_acs_s),
    .dec_o (dec_s)
  );

  // Next-state and datapath logic for the load / ACS / traceback sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cw_d     = cw_q;
    pm_d     = pm_q;
    surv_d   = surv_q;
    step_d   = step_q;
    cur_d    = cur_q;
    msg_d    = msg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    data_d   = data_q;
    metric_d = metric_q;
    case (state_q)
      IDLE: begin
        // busy_q is still set during the done_o cycle, which keeps that cycle closed to new frames.
        if (start_i && !busy_q) begin
          cw_d   = cw_shift_s[CW_W-1:0];
          busy_d = 1'b1;
          if (NUM_BEATS == 1) begin
            state_d = ACS;
            pm_d    = PM_INIT;
            step_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      LOAD: begin
        if (start_i) begin
          cw_d = cw_shift_s[CW_W-1:0];
          if (cnt_q == CNT_W'(NUM_BEATS - 1)) begin
            state_d = ACS;
            pm_d    = PM_INIT;
            step_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ACS: begin
        cw_d           = {cw_q[CW_W-3:0], 2'b00};
        pm_d           = pm_acs_s;
        surv_d[step_q] = dec_s;
        if (step_q == SW'(STEPS - 1)) begin
          state_d = TRACE;
          cur_d   = 2'b00;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      TRACE: begin
        // Tail steps are walked but never shifted into the message.
        if (step_q < SW'(MSG_LEN)) begin
          msg_d = {cur_q[1], msg_q[MSG_LEN-1:1]};
        end else begin
          msg_d = msg_q;
        end
        cur_d = {cur_q[0], surv_q[step_q][cur_q]};
        if (step_q == '0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - SW'(1);
        end
      end
      DONE: begin
        done_d   = 1'b1;
        data_d   = msg_q;
        metric_d = pm_q[0];
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cw_q     <= '0;
      pm_q     <= '0;
      surv_q   <= '0;
      step_q   <= '0;
      cur_q    <= 2'b00;
      msg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      metric_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cw_q     <= cw_d;
      pm_q     <= pm_d;
      surv_q   <= surv_d;
      step_q   <= step_d;
      cur_q    <= cur_d;
      msg_q    <= msg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      metric_q <= metric_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;
  assign data_o      = data_q;
  assign metric_o    = metric_q;

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Bench for viterbi_frame_decoder: table vectors, corner-case sequences and random
// frames with at most two channel errors, which the code always corrects exactly.
module tb_viterbi_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a;
  logic [11:0] data_a;
  logic        busy_a, done_a, ferr_a;
  logic [15:0] dout_a;
  logic [5:0]  met_a;
  logic        start_b;
  logic [9:0]  data_b;
  logic        busy_b, done_b, ferr_b;
  logic [7:0]  dout_b;
  logic [4:0]  met_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  viterbi_frame_decoder u_dut_a (
    .clk_p_i     (clk),
    .reset_p_i   (rst),
    .start_i     (start_a),
    .data_i      (data_a),
    .busy_o      (busy_a),
    .data_o      (dout_a),
    .metric_o    (met_a),
    .done_o      (done_a),
    .frame_err_o (ferr_a)
  );

  viterbi_frame_decoder #(.MSG_LEN(8), .BEAT_W(10)) u_dut_b (
    .clk_p_i     (clk),
    .reset_p_i   (rst),
    .start_i     (start_b),
    .data_i      (data_b),
    .busy_o      (busy_b),
    .data_o      (dout_b),
    .metric_o    (met_b),
    .done_o      (done_b),
    .frame_err_o (ferr_b)
  );

  typedef struct {
    logic [15:0] msg;
    logic [35:0] flips;
    logic [15:0] exp_data;
    logic [5:0]  exp_metric;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: terminated K=3 code, first pair ends up in the highest bits.
  function automatic logic [63:0] encode(input logic [31:0] msg, input int len);
    logic [63:0] cw;
    logic s1, s0, u;
    cw = '0;
    s1 = 1'b0;
    s0 = 1'b0;
    for (int t = 0; t < len + 2; t++) begin
      u  = (t < len) ? msg[len-1-t] : 1'b0;
      cw = {cw[61:0], u ^ s1 ^ s0, u ^ s0};
      s0 = s1;
      s1 = u;
    end
    return cw;
  endfunction

  task automatic send_a(input logic [35:0] cw, input logic [15:0] exp_d, input logic [5:0] exp_m,
                        input string name, input int poke);
    int   lat;
    logic busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (b > 0 && !busy_a) busy_ok = 1'b0;
      start_a = 1'b1;
      data_a  = cw[35-12*b -: 12];
    end
    @(negedge clk);
    start_a = 1'b0;
    data_a  = 12'h000;
    if (!busy_a) busy_ok = 1'b0;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(negedge clk);
      start_a = (poke > 0 && n == poke);
      data_a  = 12'hFFF;
      if (done_a) lat = n;
      else if (!busy_a) busy_ok = 1'b0;
    end
    start_a = 1'b0;
    check({name, " latency"}, 64'(lat), 64'd37);
    check({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({name, " data"}, {48'd0, dout_a}, {48'd0, exp_d});
    check({name, " metric"}, {58'd0, met_a}, {58'd0, exp_m});
    @(negedge clk);
    check({name, " done/busy drop"}, {62'd0, done_a, busy_a}, 64'd0);
  endtask

  initial begin
    logic [63:0] full;
    logic [35:0] cw;
    logic [19:0] cwb;
    logic [15:0] msg;
    int          ne, p1, p2, lat, seen;

    tbl[0] = '{16'h0000, 36'h0,                            16'h0000, 6'd0};
    tbl[1] = '{16'hA5C3, 36'h0,                            16'hA5C3, 6'd0};
    tbl[2] = '{16'hA5C3, 36'h1 << 10,                      16'hA5C3, 6'd1};
    tbl[3] = '{16'hA5C3, (36'h1 << 3) | (36'h1 << 30),     16'hA5C3, 6'd2};
    tbl[4] = '{16'h8001, (36'h1 << 35) | (36'h1 << 0),     16'h8001, 6'd2};
    tbl[5] = '{16'h1234, 36'h1 << 17,                      16'h1234, 6'd1};

    rst = 1'b1; start_a = 1'b0; data_a = 12'h000; start_b = 1'b0; data_b = 10'h000;
    repeat (3) @(negedge clk);
    check("reset a", {38'd0, busy_a, done_a, ferr_a, dout_a, met_a}, 64'd0);
    check("reset b", {45'd0, busy_b, done_b, ferr_b, dout_b, met_b}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      full = encode({16'd0, tbl[i].msg}, 16);
      cw   = full[35:0] ^ tbl[i].flips;
      send_a(cw, tbl[i].exp_data, tbl[i].exp_metric, $sformatf("vec%0d", i), 0);
    end

    // Truncated frame: two beats then start_i drops.
    full = encode({16'd0, 16'h5555}, 16);
    @(negedge clk); start_a = 1'b1; data_a = full[35:24];
    @(negedge clk); data_a = full[23:12];
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    check("trunc err pulse", {44'd0, ferr_a, busy_a, done_a, dout_a}, {44'd0, 1'b1, 1'b0, 1'b0, 16'h1234});
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done_a || ferr_a) seen++;
    end
    check("trunc no done", 64'(seen), 64'd0);
    full = encode({16'd0, 16'h1234}, 16);
    send_a(full[35:0], 16'h1234, 6'd0, "after trunc", 0);

    // Reset five cycles into ACS.
    full = encode({16'd0, 16'h0F0F}, 16);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); start_a = 1'b1; data_a = full[35-12*b -: 12];
    end
    @(negedge clk); start_a = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset mid acs", {38'd0, busy_a, done_a, ferr_a, dout_a, met_a}, 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("no done after reset", 64'(seen), 64'd0);
    full = encode({16'd0, 16'hFFFF}, 16);
    send_a(full[35:0], 16'hFFFF, 6'd0, "ffff", 0);

    // start_i pulse while tracing back must be ignored.
    full = encode({16'd0, 16'h6C19}, 16);
    send_a(full[35:0] ^ (36'h1 << 20), 16'h6C19, 6'd1, "poke trace", 25);
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("poke ignored", 64'(seen), 64'd0);

    // Random frames with up to two coded-bit errors.
    for (int r = 0; r < 12; r++) begin
      msg  = 16'($urandom);
      ne   = $urandom_range(0, 2);
      p1   = $urandom_range(0, 35);
      p2   = (p1 + $urandom_range(1, 35)) % 36;
      full = encode({16'd0, msg}, 16);
      cw   = full[35:0];
      if (ne >= 1) cw[p1] = ~cw[p1];
      if (ne >= 2) cw[p2] = ~cw[p2];
      send_a(cw, msg, 6'(ne), $sformatf("rand%0d", r), 0);
    end

    // Reduced configuration: 8-bit message, two 10-bit beats, one error.
    full = encode({24'd0, 8'h5A}, 8);
    cwb  = full[19:0] ^ (20'h1 << 7);
    @(negedge clk); start_b = 1'b1; data_b = cwb[19:10];
    @(negedge clk); data_b = cwb[9:0];
    @(negedge clk); start_b = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (done_b) lat = n;
    end
    check("small latency", 64'(lat), 64'd21);
    check("small data", {56'd0, dout_b}, 64'h5A);
    check("small metric", {59'd0, met_b}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
